// File: rtl/odyssey_pot_filter_if.sv
// Joystick-axis in / spot-position out bundle between hps_io and the Odyssey core.
// The core-side conditioner is the slave; whoever supplies VSync and axes is the master.
interface odyssey_pot_filter_if;
    logic        vsync;
    logic        mode_rel;
    logic [63:0] axis_in;
    logic [63:0] pos_out;
    logic        pos_valid;
    logic        busy;

    modport master (
        output vsync, mode_rel, axis_in,
        input  pos_out, pos_valid, busy
    );

    modport slave (
        input  vsync, mode_rel, axis_in,
        output pos_out, pos_valid, busy
    );
endinterface

// File: rtl/odyssey_pot_filter.sv
// Per-frame analog axis conditioner: snapshot on VSync, then one axis per clock
// through a shared deadzone / slew-limit (absolute) or integrate (relative) datapath.
module odyssey_pot_filter #(
    parameter int DEADZONE  = 8,
    parameter int SLEW_MAX  = 6,
    parameter int REL_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    odyssey_pot_filter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PROC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [8:0]        DZ_LIM   = 9'(DEADZONE);
    localparam logic signed [9:0] SLEW_LIM = 10'(SLEW_MAX);

    logic [1:0]  state_reg;
    logic [2:0]  idx_reg;
    logic [63:0] shadow_reg;
    logic        mode_reg;
    logic        vsync_prev_reg;
    logic        pos_valid_reg;
    logic        busy_reg;
    logic [7:0]  pos_reg [8];

    logic vsync_edge;
    assign vsync_edge = bus.vsync & ~vsync_prev_reg;

    // Shared datapath operating on axis idx_reg
    logic signed [7:0] axis_v;
    logic signed [8:0] axis_x;
    logic [8:0]        axis_mag;
    logic signed [7:0] axis_dz;
    logic [7:0]        cur_pos;
    logic [7:0]        target;
    logic signed [9:0] delta;
    logic signed [9:0] delta_lim;
    logic signed [9:0] abs_sum;
    logic signed [7:0] rel_step;
    logic signed [9:0] rel_sum;
    logic [7:0]        abs_new;
    logic [7:0]        rel_new;
    logic [7:0]        pos_new;

    assign axis_v   = $signed(shadow_reg[{idx_reg, 3'b000} +: 8]);
    assign axis_x   = {axis_v[7], axis_v};
    assign axis_mag = axis_v[7] ? 9'(-axis_x) : 9'(axis_x);
    assign axis_dz  = (axis_mag <= DZ_LIM) ? 8'sd0 : axis_v;
    assign cur_pos  = pos_reg[idx_reg];

    // Flipping the sign bit maps signed -128..127 onto unsigned 0..255
    assign target = {~axis_dz[7], axis_dz[6:0]};
    assign delta  = $signed({2'b00, target}) - $signed({2'b00, cur_pos});

    always_comb begin
        delta_lim = delta;
        if (SLEW_MAX != 0) begin
            if (delta > SLEW_LIM) begin
                delta_lim = SLEW_LIM;
            end else if (delta < -SLEW_LIM) begin
                delta_lim = -SLEW_LIM;
            end
        end
    end

    assign abs_sum = $signed({2'b00, cur_pos}) + delta_lim;
    assign abs_new = abs_sum[7:0];

    assign rel_step = axis_dz >>> REL_SHIFT;
    assign rel_sum  = $signed({2'b00, cur_pos}) + $signed({{2{rel_step[7]}}, rel_step});

    always_comb begin
        rel_new = rel_sum[7:0];
        if (rel_sum < 10'sd0) begin
            rel_new = 8'd0;
        end else if (rel_sum > 10'sd255) begin
            rel_new = 8'd255;
        end
    end

    assign pos_new = mode_reg ? rel_new : abs_new;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= 3'd0;
            shadow_reg     <= 64'd0;
            mode_reg       <= 1'b0;
            vsync_prev_reg <= 1'b0;
            pos_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                pos_reg[i] <= 8'd128;
            end
        end else begin
            vsync_prev_reg <= bus.vsync;
            pos_valid_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (vsync_edge) begin
                        shadow_reg <= bus.axis_in;
                        mode_reg   <= bus.mode_rel;
                        idx_reg    <= 3'd0;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_PROC;
                    end
                end
                ST_PROC: begin
                    pos_reg[idx_reg] <= pos_new;
                    idx_reg          <= idx_reg + 3'd1;
                    if (idx_reg == 3'd7) begin
                        pos_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pos_out
            assign bus.pos_out[gi*8 +: 8] = pos_reg[gi];
        end
    endgenerate

    assign bus.pos_valid = pos_valid_reg;
    assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_odyssey_pot_filter.sv
// Randomized + directed bench for odyssey_pot_filter: two instances (slew-limited and
// unlimited) driven in lockstep and compared against a per-frame arithmetic model.
module tb_odyssey_pot_filter;

    localparam int DZ     = 8;
    localparam int SLEW_A = 6;
    localparam int SLEW_B = 0;
    localparam int SHIFT  = 4;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        mode_rel;
    logic [63:0] axis_in;

    odyssey_pot_filter_if ifa ();
    odyssey_pot_filter_if ifb ();

    assign ifa.vsync    = vsync;
    assign ifa.mode_rel = mode_rel;
    assign ifa.axis_in  = axis_in;
    assign ifb.vsync    = vsync;
    assign ifb.mode_rel = mode_rel;
    assign ifb.axis_in  = axis_in;

    odyssey_pot_filter #(.DEADZONE(DZ), .SLEW_MAX(SLEW_A), .REL_SHIFT(SHIFT)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    odyssey_pot_filter #(.DEADZONE(DZ), .SLEW_MAX(SLEW_B), .REL_SHIFT(SHIFT)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mdl_a [8];
    int mdl_b [8];
    int frame_no = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame of the conditioning rules, in plain integer arithmetic
    function automatic int mdl_next(input int cur, input int v, input bit rel, input int slew);
        int vd;
        int step;
        int d;
        int n;
        vd = ((v < 0) ? -v : v) <= DZ ? 0 : v;
        if (rel) begin
            step = (vd >= 0) ? (vd / (1 << SHIFT)) : -((-vd + (1 << SHIFT) - 1) / (1 << SHIFT));
            n = cur + step;
            if (n < 0) n = 0;
            if (n > 255) n = 255;
        end else begin
            d = (vd + 128) - cur;
            if (slew != 0) begin
                if (d > slew) d = slew;
                if (d < -slew) d = -slew;
            end
            n = cur + d;
        end
        return n;
    endfunction

    function automatic int axis_of(input logic [63:0] ax, input int i);
        logic [7:0] b;
        b = ax[8*i +: 8];
        return int'($signed(b));
    endfunction

    function automatic int pick_axis();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 8;
            2: return -8;
            3: return 9;
            4: return -9;
            5: return 127;
            6: return -128;
            default: return int'($urandom_range(0, 255)) - 128;
        endcase
    endfunction

    function automatic int pos_a(input int i);
        logic [63:0] p;
        p = ifa.pos_out;
        return int'(p[8*i +: 8]);
    endfunction

    function automatic int pos_b(input int i);
        logic [63:0] p;
        p = ifb.pos_out;
        return int'(p[8*i +: 8]);
    endfunction

    task automatic compare_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("%s_a%0d", tag, i), 32'(pos_a(i)), 32'(mdl_a[i]));
            check_val($sformatf("%s_b%0d", tag, i), 32'(pos_b(i)), 32'(mdl_b[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mdl_a[i] = 128;
            mdl_b[i] = 128;
        end
    endtask

    // Runs one update pass; optionally re-pulses vsync and scrambles axis_in mid-pass
    task automatic do_frame(input logic [63:0] ax, input bit rel, input bit disturb);
        int na [8];
        int nb [8];
        int valid_a;
        int valid_b;
        for (int i = 0; i < 8; i++) begin
            na[i] = mdl_next(mdl_a[i], axis_of(ax, i), rel, SLEW_A);
            nb[i] = mdl_next(mdl_b[i], axis_of(ax, i), rel, SLEW_B);
        end
        valid_a = 0;
        valid_b = 0;
        @(negedge clk);
        axis_in  = ax;
        mode_rel = rel;
        vsync    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) vsync = 1'b0;
            if (disturb && k == 2) begin
                axis_in  = {$urandom, $urandom};
                mode_rel = ~rel;
            end
            if (disturb && k == 4) vsync = 1'b1;
            valid_a += int'(ifa.pos_valid);
            valid_b += int'(ifb.pos_valid);
            if (k <= 9) begin
                check_val($sformatf("busy_k%0d", k), 32'(ifa.busy), 32'd1);
                check_val($sformatf("valid_k%0d", k), 32'(ifa.pos_valid), 32'(k == 9));
            end else if (k == 10) begin
                check_val("busy_after", 32'(ifb.busy), 32'd0);
            end
            if (k == 2) begin
                check_val("byte0_first", 32'(pos_a(0)), 32'(na[0]));
                check_val("byte1_not_yet", 32'(pos_a(1)), 32'(mdl_a[1]));
            end
        end
        vsync = 1'b0;
        check_val("valid_count_a", 32'(valid_a), 32'd1);
        check_val("valid_count_b", 32'(valid_b), 32'd1);
        for (int i = 0; i < 8; i++) begin
            mdl_a[i] = na[i];
            mdl_b[i] = nb[i];
        end
        frame_no++;
        compare_all($sformatf("f%0d", frame_no));
        $display("frame %0d rel=%0d axes=%016h pos_a=%016h pos_b=%016h", frame_no, rel, ax,
                 ifa.pos_out, ifb.pos_out);
    endtask

    // Starts a pass and slams reset while axis 4 is being processed
    task automatic reset_mid_pass(input logic [63:0] ax);
        @(negedge clk);
        axis_in  = ax;
        mode_rel = 1'b0;
        vsync    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) vsync = 1'b0;
        end
        reset = 1'b1;
        #1;
        model_reset();
        check_val("rst_busy", 32'(ifa.busy), 32'd0);
        check_val("rst_valid", 32'(ifa.pos_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("rst_byte%0d", i), 32'(pos_a(i)), 32'd128);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset mid-pass applied");
    endtask

    initial begin
        logic [63:0] ax;
        reset    = 1'b1;
        vsync    = 1'b0;
        mode_rel = 1'b0;
        axis_in  = 64'd0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("init_busy", 32'(ifa.busy), 32'd0);
        check_val("init_valid", 32'(ifa.pos_valid), 32'd0);
        compare_all("init");

        // Unlimited slew: +100 lands immediately at 228
        do_frame(64'h0000_0000_0000_0064, 1'b0, 1'b0);
        check_val("abs_plus100", 32'(pos_b(0)), 32'd228);
        check_val("abs_other", 32'(pos_b(5)), 32'd128);

        // Deadzone edges: +8, -8, +9, -128
        do_frame(64'h0000_0000_8009_F808, 1'b0, 1'b0);
        check_val("dz_p8", 32'(pos_b(0)), 32'd128);
        check_val("dz_m8", 32'(pos_b(1)), 32'd128);
        check_val("dz_p9", 32'(pos_b(2)), 32'd137);
        check_val("dz_m128", 32'(pos_b(3)), 32'd0);

        reset_mid_pass(64'h7F7F_7F7F_7F7F_7F7F);
        compare_all("post_rst");

        // Slew-limited descent of 2YP2
        for (int f = 1; f <= 23; f++) begin
            do_frame(64'h8000_0000_0000_0000, 1'b0, 1'b0);
            if (f == 1)  check_val("slew_f1", 32'(pos_a(7)), 32'd122);
            if (f == 21) check_val("slew_f21", 32'(pos_a(7)), 32'd2);
            if (f >= 22) check_val("slew_floor", 32'(pos_a(7)), 32'd0);
        end

        reset_mid_pass(64'h0000_0000_0000_0000);

        // Relative integration with saturation at both ends
        for (int f = 1; f <= 20; f++) begin
            do_frame(64'h0000_807F_0000_0000, 1'b1, 1'b0);
            if (f == 18) check_val("rel_f18", 32'(pos_a(4)), 32'd254);
            if (f >= 19) check_val("rel_sat_hi", 32'(pos_a(4)), 32'd255);
            if (f == 15) check_val("rel_f15", 32'(pos_a(5)), 32'd8);
            if (f >= 16) check_val("rel_sat_lo", 32'(pos_b(5)), 32'd0);
        end

        // Second vsync edge mid-pass is ignored; shadow holds the snapshot
        do_frame(64'h10F0_2AD6_7F80_0C9C, 1'b0, 1'b1);

        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 8; i++) begin
                ax[8*i +: 8] = 8'(pick_axis());
            end
            do_frame(ax, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
